// File: rtl/macc_pkg.sv
// Shared definitions for the MACC multiplier path: operand width and
// sequencer state encoding.
package macc_pkg;

    localparam int MULT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negate: y = neg ? (~x + 1) : x.
// The increment is a ripple carry chain seeded by neg, so no adder is inferred.
module cond_neg #(
    parameter int N = 5
) (
    input  logic [N-1:0] x,
    input  logic         neg,
    output logic [N-1:0] y
);

    logic carry;
    logic inv_bit;

    always_comb begin
        y       = '0;
        carry   = neg;
        inv_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            inv_bit = x[i] ^ neg;
            y[i]    = inv_bit ^ carry;
            carry   = inv_bit & carry;
        end
    end

endmodule

// File: rtl/seq_signed_mult.sv
// Sequential radix-2 signed multiplier: sign/magnitude split, W-cycle
// shift-add on the magnitudes, then a 2W-bit conditional negate.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// MUL   | shift-add, one multiplier bit per cycle, W cycles
// SIGN  | apply product sign and register p
// DONE  | p valid, held until out_ready
module seq_signed_mult
    import macc_pkg::*;
#(
    parameter int W     = MULT_W,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    state_t           state;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic             sign;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   acc;

    logic [W-1:0]     abs_a;
    logic [W-1:0]     abs_b;
    logic [2*W-1:0]   acc_signed;
    logic [2*W-1:0]   addend;
    logic             operand_zero;

    cond_neg #(.N(W)) u_abs_a (
        .x   (a),
        .neg (a[W-1]),
        .y   (abs_a)
    );

    cond_neg #(.N(W)) u_abs_b (
        .x   (b),
        .neg (b[W-1]),
        .y   (abs_b)
    );

    cond_neg #(.N(2*W)) u_sign_fix (
        .x   (acc),
        .neg (sign),
        .y   (acc_signed)
    );

    // A zero operand forces a positive sign so p is never a negated zero.
    assign operand_zero = (a == '0) || (b == '0);
    assign addend       = mag_b[0] ? ({{W{1'b0}}, mag_a} << cnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            cnt       <= '0;
            acc       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        mag_a    <= abs_a;
                        mag_b    <= abs_b;
                        sign     <= (a[W-1] ^ b[W-1]) && !operand_zero;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc   <= acc + addend;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    p         <= acc_signed;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_mult.sv
// Scoreboard bench for seq_signed_mult: directed products, backpressure,
// mid-operation reset and a randomized stream with valid/ready stalls.
module tb_seq_signed_mult;
    import macc_pkg::*;

    localparam int W  = MULT_W;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] p;

    int            errors = 0;
    int            checks = 0;
    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    seq_signed_mult #(.W(W), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int ix;
        int iy;
        ix = $signed(x);
        iy = $signed(y);
        return PW'(ix * iy);
    endfunction

    // Offers one pair, waits for acceptance, then counts edges until out_valid.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [PW-1:0] got, output int lat, output bit timed_out);
        int  n;
        bit  acc_ok;
        timed_out = 1'b0;
        got       = '0;
        lat       = 0;
        n         = 0;
        acc_ok    = 1'b0;
        @(posedge clk);
        #1;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        while (!acc_ok && n < 100) begin
            @(negedge clk);
            acc_ok = in_ready;
            @(posedge clk);
            n++;
        end
        #1 in_valid = 1'b0;
        if (!acc_ok) begin
            timed_out = 1'b1;
            return;
        end
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 50);
        if (!out_valid) timed_out = 1'b1;
        got = p;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 5'd3;
        b         = 5'd3;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (p !== '0) begin errors++; $display("FAIL reset_p: got %h expected 000", p); end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_valid_ignored: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0]  ta[5];
        logic [W-1:0]  tb_op[5];
        logic [PW-1:0] tp[5];
        logic [PW-1:0] got;
        logic [PW-1:0] e;
        int            lat;
        bit            to;
        ta = '{5'd3, 5'h10, 5'h10, 5'd0, 5'h1F};
        tb_op = '{5'd5, 5'h10, 5'h0F, 5'h19, 5'd1};
        tp = '{10'h00F, 10'h100, 10'h310, 10'h000, 10'h3FF};
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tp[i]);
            do_op(ta[i], tb_op[i], got, lat, to);
            e = exp_q.pop_front();
            checks++;
            if (to) begin
                errors++;
                $display("FAIL basic_timeout[%0d]: got no product expected %h", i, e);
                continue;
            end
            checks++;
            if (got !== e) begin errors++; $display("FAIL basic_p[%0d]: got %h expected %h", i, got, e); end
            checks++;
            if (lat !== W + 1) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] got;
        logic [PW-1:0] e;
        int            lat;
        bit            to;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_q.push_back(10'h3EB);
        do_op(5'h1D, 5'd7, got, lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_timeout: got no product expected %h", e);
            out_ready = 1'b1;
            return;
        end
        // A second pair is offered during the stall and must wait for IDLE.
        a        = 5'd4;
        b        = 5'h1B;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (p !== e) begin errors++; $display("FAIL bp_p_held[%0d]: got %h expected %h", i, p, e); end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        exp_q.push_back(ref_mul(5'd4, 5'h1B));
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (p !== e || !out_valid) begin errors++; $display("FAIL bp_second_p: got %h expected %h", p, e); end
        checks++;
        if (lat !== W + 1) begin errors++; $display("FAIL bp_second_latency: got %0d expected %0d", lat, W + 1); end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] got;
        logic [PW-1:0] e;
        int            lat;
        int            n;
        bit            to;
        bit            acc_ok;
        @(posedge clk);
        #1;
        a        = 5'd7;
        b        = 5'd3;
        in_valid = 1'b1;
        n        = 0;
        acc_ok   = 1'b0;
        while (!acc_ok && n < 100) begin
            @(negedge clk);
            acc_ok = in_ready;
            @(posedge clk);
            n++;
        end
        #1 in_valid = 1'b0;
        checks++;
        if (!acc_ok) begin errors++; $display("FAIL rstmid_accept: got no accept expected accept"); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== '0) begin
            errors++;
            $display("FAIL rstmid_state: got in_ready=%b out_valid=%b p=%h expected 1/0/000", in_ready, out_valid, p);
        end
        exp_q.push_back(10'h004);
        do_op(5'd2, 5'd2, got, lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e) begin errors++; $display("FAIL rstmid_next_p: got %h expected %h", got, e); end
    endtask

    task automatic test_random();
        int rcv;
        int cyc;
        int sent;
        @(posedge clk);
        #1;
        rcv  = 0;
        cyc  = 0;
        sent = 0;
        fork
            begin : driver
                bit abort;
                abort = 1'b0;
                for (int i = 0; i < 1000 && !abort; i++) begin
                    int  n;
                    bit  acc_ok;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    @(posedge clk);
                    #1;
                    a        = W'($urandom_range(0, 31));
                    b        = W'($urandom_range(0, 31));
                    in_valid = 1'b1;
                    n        = 0;
                    acc_ok   = 1'b0;
                    while (!acc_ok && n < 200) begin
                        @(negedge clk);
                        acc_ok = in_ready;
                        @(posedge clk);
                        n++;
                    end
                    if (acc_ok) begin
                        exp_q.push_back(ref_mul(a, b));
                        sent++;
                    end else begin
                        abort = 1'b1;
                    end
                    #1 in_valid = 1'b0;
                end
            end
            begin : receiver
                logic [PW-1:0] e;
                while (rcv < 1000 && cyc < 40000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra: got product %h expected none", p);
                        end else begin
                            e = exp_q.pop_front();
                            if (p !== e) begin errors++; $display("FAIL rand_p[%0d]: got %h expected %h", rcv, p, e); end
                        end
                        rcv++;
                    end
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        checks++;
        if (rcv !== 1000 || sent !== 1000) begin
            errors++;
            $display("FAIL rand_count: got sent=%0d received=%0d expected 1000/1000", sent, rcv);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_leftover: got %0d pending expected 0", exp_q.size()); end
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_duplicate: got out_valid=%b expected 0", out_valid); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
